rampa_motor: RTL and testbench

//  Speed/direction sequencer directly upstream of controlador_motor; drives its sel and pwm_duty.

---
 rtl/rampa_motor.sv | 172 +++++++++++++++++
 tb/tb_rampa_motor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rampa_motor.sv
// rampa_motor: soft-start/soft-stop duty sequencer in front of controlador_motor.
// Turns raw direction/duty commands into a stepped duty ramp, forces every
// reversal through zero duty plus a dead time, and maps fault to sel=11.
module rampa_motor #(
    parameter int RAMP_DIV    = 50000,   // clocks per ramp tick
    parameter int STEP        = 1,       // duty change per tick
    parameter int DEAD_CYCLES = 500000   // clocks at sel=00 between directions
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd_dir,
    input  logic [7:0] target_duty,
    input  logic       fault,
    output logic [1:0] sel,
    output logic [7:0] pwm_duty,
    output logic       busy,
    output logic       at_target
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);
    localparam logic [8:0]    STEP9      = 9'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DEAD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [1:0]    cur_dir, cur_dir_n;
    logic [7:0]    duty, duty_n;
    logic [PW-1:0] presc, presc_n;
    logic [DW-1:0] dead_cnt, dead_cnt_n;
    logic [1:0]    sel_n;
    logic          busy_n;
    logic          at_target_n;

    logic          cmd_valid;
    logic          tick;
    logic [7:0]    eff_target;
    logic [8:0]    up_sum;
    logic [8:0]    dn_floor;
    logic [8:0]    dn_diff;
    logic [7:0]    ramp_duty;

    // Anything other than a real direction (stop, 11, or a reversal request)
    // ramps toward zero; the ramp math is 9 bits wide so it never wraps.
    assign cmd_valid  = (cmd_dir == 2'b01) || (cmd_dir == 2'b10);
    assign tick       = (presc == PRESC_LAST);
    assign eff_target = (cmd_dir == cur_dir) ? target_duty : 8'd0;
    assign up_sum     = {1'b0, duty} + STEP9;
    assign dn_floor   = {1'b0, eff_target} + STEP9;
    assign dn_diff    = {1'b0, duty} - STEP9;

    // One ramp step toward eff_target, clamped so it never overshoots.
    always_comb begin
        ramp_duty = duty;
        if (duty < eff_target) begin
            ramp_duty = (up_sum > {1'b0, eff_target}) ? eff_target : up_sum[7:0];
        end else if (duty > eff_target) begin
            ramp_duty = ({1'b0, duty} < dn_floor) ? eff_target : dn_diff[7:0];
        end
    end

    // Next-state and next-output logic; fault overrides every state.
    always_comb begin
        state_n    = state;
        cur_dir_n  = cur_dir;
        duty_n     = duty;
        presc_n    = presc;
        dead_cnt_n = dead_cnt;

        if (fault) begin
            state_n    = FAULT;
            duty_n     = 8'd0;
            presc_n    = '0;
            dead_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    duty_n     = 8'd0;
                    presc_n    = '0;
                    dead_cnt_n = '0;
                    if (cmd_valid && (target_duty != 8'd0)) begin
                        cur_dir_n = cmd_dir;
                        state_n   = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc_n = '0;
                        duty_n  = ramp_duty;
                        // Reached zero while the command no longer matches:
                        // a valid opposite direction goes through dead time.
                        if ((ramp_duty == 8'd0) && (eff_target == 8'd0) &&
                            (cmd_dir != cur_dir)) begin
                            dead_cnt_n = '0;
                            state_n    = cmd_valid ? DEAD : IDLE;
                        end
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end
                DEAD: begin
                    duty_n = 8'd0;
                    if (dead_cnt == DEAD_LAST) begin
                        dead_cnt_n = '0;
                        if (cmd_valid) begin
                            cur_dir_n = cmd_dir;
                            state_n   = RUN;
                        end else begin
                            state_n   = IDLE;
                        end
                    end else begin
                        dead_cnt_n = dead_cnt + DW'(1);
                    end
                end
                FAULT: begin
                    duty_n     = 8'd0;
                    presc_n    = '0;
                    dead_cnt_n = '0;
                    // No auto-restart: the command must return to stop first.
                    if (cmd_dir == 2'b00) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        case (state_n)
            RUN:     sel_n = cur_dir_n;
            FAULT:   sel_n = 2'b11;
            default: sel_n = 2'b00;
        endcase
        busy_n      = (state_n != IDLE);
        at_target_n = (state_n == RUN) && (cmd_dir == cur_dir_n) &&
                      (duty_n == target_duty);
    end

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_dir   <= 2'b00;
            duty      <= 8'd0;
            presc     <= '0;
            dead_cnt  <= '0;
            sel       <= 2'b00;
            pwm_duty  <= 8'd0;
            busy      <= 1'b0;
            at_target <= 1'b0;
        end else begin
            state     <= state_n;
            cur_dir   <= cur_dir_n;
            duty      <= duty_n;
            presc     <= presc_n;
            dead_cnt  <= dead_cnt_n;
            sel       <= sel_n;
            pwm_duty  <= duty_n;
            busy      <= busy_n;
            at_target <= at_target_n;
        end
    end

endmodule

// File: tb/tb_rampa_motor.sv
// Bench for rampa_motor: behavioural model predicts the outputs every clock,
// a monitor pops and compares; directed phases plus random command segments.
module tb_rampa_motor;

    localparam int RD = 4;
    localparam int ST = 16;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] cmd_dir = 2'b00;
    logic [7:0] target_duty = 8'd0;
    logic       fault = 1'b0;
    logic [1:0] sel;
    logic [7:0] pwm_duty;
    logic       busy;
    logic       at_target;

    rampa_motor #(.RAMP_DIV(RD), .STEP(ST), .DEAD_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_dir     (cmd_dir),
        .target_duty (target_duty),
        .fault       (fault),
        .sel         (sel),
        .pwm_duty    (pwm_duty),
        .busy        (busy),
        .at_target   (at_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] duty;
        logic       busy;
        logic       at;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // Model modes (plain integers, not the DUT encoding).
    localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2, M_FLT = 3;
    int m_mode = M_IDLE;
    int m_dir = 0;
    int m_duty = 0;
    int run_clk = 0;
    int dead_left = 0;

    // Reference model: advance one clock using the inputs seen at this edge.
    always @(posedge clk) begin : model
        int c, t, eff;
        exp_t e;
        c = int'(cmd_dir);
        t = int'(target_duty);
        if (!rst) begin
            m_mode = M_IDLE; m_dir = 0; m_duty = 0; run_clk = 0; dead_left = 0;
        end else if (fault) begin
            m_mode = M_FLT; m_duty = 0; run_clk = 0; dead_left = 0;
        end else begin
            case (m_mode)
                M_IDLE: if ((c == 1 || c == 2) && t != 0) begin
                    m_dir = c; m_mode = M_RUN; m_duty = 0; run_clk = 0;
                end
                M_RUN: begin
                    run_clk++;
                    if (run_clk == RD) begin
                        run_clk = 0;
                        eff = (c == m_dir) ? t : 0;
                        if (m_duty < eff)
                            m_duty = (m_duty + ST > eff) ? eff : m_duty + ST;
                        else if (m_duty > eff)
                            m_duty = (m_duty - ST < eff) ? eff : m_duty - ST;
                        if (m_duty == 0 && eff == 0 && c != m_dir) begin
                            if (c == 1 || c == 2) begin
                                m_mode = M_DEAD; dead_left = DC;
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                    end
                end
                M_DEAD: begin
                    dead_left--;
                    if (dead_left == 0) begin
                        if (c == 1 || c == 2) begin
                            m_dir = c; m_mode = M_RUN; m_duty = 0; run_clk = 0;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                default: if (c == 0) m_mode = M_IDLE;
            endcase
        end
        e.sel  = (m_mode == M_RUN) ? 2'(m_dir) : (m_mode == M_FLT) ? 2'b11 : 2'b00;
        e.duty = 8'(m_duty);
        e.busy = (m_mode != M_IDLE);
        e.at   = (m_mode == M_RUN) && (c == m_dir) && (m_duty == t);
        q.push_back(e);
    end

    // Monitor: every falling edge compare DUT outputs with the oldest prediction.
    always @(negedge clk) begin : monitor
        exp_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (!rst) e = '0;
            a = {sel, pwm_duty, busy, at_target};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got sel=%b duty=%0d busy=%b at=%b want sel=%b duty=%0d busy=%b at=%b",
                         $time, a.sel, a.duty, a.busy, a.at, e.sel, e.duty, e.busy, e.at);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
        end
    endtask

    // Bounded wait for a given duty value, sampled on falling edges.
    task automatic wait_duty(input string nm, input int want, input int lim);
        int n;
        n = 0;
        while (int'(pwm_duty) != want && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(pwm_duty), want);
    endtask

    initial begin
        // Reset and release with stop commanded
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(4);
        chk("idle_after_reset_busy", busy, 0);

        // Start CW to 128
        cmd_dir = 2'b01; target_duty = 8'd128;
        cyc(40);
        chk("start_duty", pwm_duty, 128);
        chk("start_at_target", at_target, 1);

        // Reversal through dead time to CCW 128
        cmd_dir = 2'b10;
        cyc(90);
        chk("rev_sel", sel, 2);
        chk("rev_duty", pwm_duty, 128);

        // Retargets, including saturation at 255
        target_duty = 8'd100; cyc(20);
        chk("retarget100", pwm_duty, 100);
        target_duty = 8'd40;  cyc(24);
        chk("retarget40", pwm_duty, 40);
        target_duty = 8'd255; cyc(70);
        chk("sat255", pwm_duty, 255);

        // Stop from full speed
        cmd_dir = 2'b00; cyc(80);
        chk("stop_busy", busy, 0);

        // Asynchronous reset mid-ramp at duty 64
        cmd_dir = 2'b01; target_duty = 8'd128;
        wait_duty("rst_pre_duty", 64, 60);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_sel", sel, 0);
        chk("async_rst_duty", pwm_duty, 0);
        chk("async_rst_busy", busy, 0);
        cmd_dir = 2'b00;
        cyc(2);
        #2 rst = 1'b1;
        cyc(5);
        chk("rst_release_busy", busy, 0);

        // Fault at duty 64, no auto-restart
        cmd_dir = 2'b01; target_duty = 8'd128;
        wait_duty("fault_pre_duty", 64, 60);
        fault = 1'b1; cyc(1);
        chk("fault_sel", sel, 3);
        chk("fault_duty", pwm_duty, 0);
        cyc(2);
        fault = 1'b0; cyc(5);
        chk("fault_hold_sel", sel, 3);
        cmd_dir = 2'b00; cyc(2);
        chk("fault_exit_sel", sel, 0);
        chk("fault_exit_busy", busy, 0);

        // Stop from 48, then a zero-target start stays idle
        cmd_dir = 2'b01; target_duty = 8'd48;
        wait_duty("stop_pre_duty", 48, 40);
        cmd_dir = 2'b00; cyc(20);
        chk("stop48_sel", sel, 0);
        chk("stop48_duty", pwm_duty, 0);
        cmd_dir = 2'b01; target_duty = 8'd0; cyc(10);
        chk("zero_target_busy", busy, 0);

        // Random command segments
        for (int s = 0; s < 150; s++) begin
            int r;
            r = $urandom_range(0, 9);
            cmd_dir = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       target_duty = 8'd0;
                1:       target_duty = 8'd255;
                default: target_duty = 8'($urandom_range(0, 255));
            endcase
            fault = ($urandom_range(0, 19) == 0);
            cyc($urandom_range(1, 40));
            fault = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                #2 rst = 1'b0;
                cyc(1);
                #2 rst = 1'b1;
            end
        end

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
